// File: rtl/ntt_pkg.sv
// ---------------------------------------------------------------------------
// ntt_pkg
// Shared constants and types for the 128-point mixed-radix NTT datapath.
//   ADDR_W        : data-memory address width (N = 128)
//   NUM_STAGES    : stages per transform, processed 3, 2, 1, 0
//   BF_PER_STAGE  : radix-4 butterflies per stage
//   stage_t       : 2-bit stage encoding
//   stageStride() : distance between the four operands of a butterfly
// ---------------------------------------------------------------------------
package ntt_pkg;

    localparam int ADDR_W       = 7;
    localparam int N            = 128;
    localparam int NUM_STAGES   = 4;
    localparam int BF_PER_STAGE = 32;
    localparam int CNT_W        = 5;

    typedef enum logic [1:0] {
        STAGE_0 = 2'd0,
        STAGE_1 = 2'd1,
        STAGE_2 = 2'd2,
        STAGE_3 = 2'd3
    } stage_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } wb_state_t;

    // Operand stride of a butterfly in the given stage.
    function automatic logic [ADDR_W-1:0] stageStride(input stage_t stage);
        logic [ADDR_W-1:0] stride;
        case (stage)
            STAGE_3: stride = 7'd32;
            STAGE_2: stride = 7'd16;
            STAGE_1: stride = 7'd4;
            default: stride = 7'd1;
        endcase
        return stride;
    endfunction

endpackage

// File: rtl/ntt_wb_addr_map.sv
// ---------------------------------------------------------------------------
// ntt_wb_addr_map
// Combinational address map: butterfly index within a stage plus the stage
// number give the four in-place memory addresses of that butterfly.
//   i_cnt    : butterfly index 0..31 within the stage
//   i_stage  : stage being processed (3..0)
//   o_addr0..o_addr3 : base + n*stride for n = 0..3
// ---------------------------------------------------------------------------
module ntt_wb_addr_map
    import ntt_pkg::*;
(
    input  logic [CNT_W-1:0]  i_cnt,
    input  stage_t            i_stage,
    output logic [ADDR_W-1:0] o_addr0,
    output logic [ADDR_W-1:0] o_addr1,
    output logic [ADDR_W-1:0] o_addr2,
    output logic [ADDR_W-1:0] o_addr3
);

    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] w_stride;

    // The base address splits the butterfly index around the stride bits:
    // low index bits stay below the stride, high index bits jump over the
    // 4*stride block the butterfly occupies.
    always_comb begin
        w_stride = stageStride(i_stage);
        w_base   = '0;
        case (i_stage)
            STAGE_3: w_base = {2'b00, i_cnt};
            STAGE_2: w_base = {i_cnt[4], 2'b00, i_cnt[3:0]};
            STAGE_1: w_base = {i_cnt[4:2], 2'b00, i_cnt[1:0]};
            default: w_base = {i_cnt, 2'b00};
        endcase
    end

    // The largest sum is 127, so 7-bit arithmetic never wraps.
    assign o_addr0 = w_base;
    assign o_addr1 = w_base + w_stride;
    assign o_addr2 = w_base + (w_stride << 1);
    assign o_addr3 = w_base + (w_stride << 1) + w_stride;

endmodule

// File: rtl/ntt_wb_addr_gen.sv
// ---------------------------------------------------------------------------
// ntt_wb_addr_gen
// Write-back address sequencer for the 128-point NTT. Counts butterfly result
// beats and registers the four in-place write addresses for each beat.
//   clk, rst     : clock, asynchronous active-high reset
//   start        : begins a transform when idle
//   res_valid    : one butterfly result beat (four results) is valid
//   wr_en        : registered write strobe for the current beat
//   wr_addr_0..3 : write addresses for results 0..3
//   cur_stage    : stage currently being written
//   busy         : transform in progress
//   stage_done   : pulses with the last write of each stage
//   done         : pulses the cycle after the last write of stage 0
//   err          : sticky, result beat seen outside a transform
// ---------------------------------------------------------------------------
module ntt_wb_addr_gen
    import ntt_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              res_valid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr_0,
    output logic [ADDR_W-1:0] wr_addr_1,
    output logic [ADDR_W-1:0] wr_addr_2,
    output logic [ADDR_W-1:0] wr_addr_3,
    output logic [1:0]        cur_stage,
    output logic              busy,
    output logic              stage_done,
    output logic              done,
    output logic              err
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BF_PER_STAGE - 1);

    wb_state_t         r_state;
    logic [CNT_W-1:0]  r_cnt;
    stage_t            r_curStage;
    logic              r_wrEn;
    logic [ADDR_W-1:0] r_wrAddr0;
    logic [ADDR_W-1:0] r_wrAddr1;
    logic [ADDR_W-1:0] r_wrAddr2;
    logic [ADDR_W-1:0] r_wrAddr3;
    logic              r_busy;
    logic              r_stageDone;
    logic              r_done;
    logic              r_err;

    logic [ADDR_W-1:0] w_addr0;
    logic [ADDR_W-1:0] w_addr1;
    logic [ADDR_W-1:0] w_addr2;
    logic [ADDR_W-1:0] w_addr3;

    ntt_wb_addr_map uAddrMap (
        .i_cnt   (r_cnt),
        .i_stage (r_curStage),
        .o_addr0 (w_addr0),
        .o_addr1 (w_addr1),
        .o_addr2 (w_addr2),
        .o_addr3 (w_addr3)
    );

    // Sequencer FSM. Strobes default low every cycle; addresses hold their
    // last value between beats. A beat arriving together with an accepted
    // start is dropped without flagging an error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_curStage  <= STAGE_3;
            r_wrEn      <= 1'b0;
            r_wrAddr0   <= '0;
            r_wrAddr1   <= '0;
            r_wrAddr2   <= '0;
            r_wrAddr3   <= '0;
            r_busy      <= 1'b0;
            r_stageDone <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_wrEn      <= 1'b0;
            r_stageDone <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_RUN;
                        r_cnt      <= '0;
                        r_curStage <= STAGE_3;
                        r_err      <= 1'b0;
                        r_busy     <= 1'b1;
                    end else if (res_valid) begin
                        r_err <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (res_valid) begin
                        r_wrEn    <= 1'b1;
                        r_wrAddr0 <= w_addr0;
                        r_wrAddr1 <= w_addr1;
                        r_wrAddr2 <= w_addr2;
                        r_wrAddr3 <= w_addr3;
                        r_cnt     <= r_cnt + 1'b1;
                        if (r_cnt == LAST_CNT) begin
                            r_stageDone <= 1'b1;
                            if (r_curStage == STAGE_0) begin
                                r_state <= ST_DONE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_curStage <= stage_t'(r_curStage - 2'd1);
                            end
                        end
                    end
                end
                ST_DONE: begin
                    r_done     <= 1'b1;
                    r_state    <= ST_IDLE;
                    r_curStage <= STAGE_3;
                    if (res_valid) begin
                        r_err <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign wr_en      = r_wrEn;
    assign wr_addr_0  = r_wrAddr0;
    assign wr_addr_1  = r_wrAddr1;
    assign wr_addr_2  = r_wrAddr2;
    assign wr_addr_3  = r_wrAddr3;
    assign cur_stage  = r_curStage;
    assign busy       = r_busy;
    assign stage_done = r_stageDone;
    assign done       = r_done;
    assign err        = r_err;

endmodule

// File: tb/tb_ntt_wb_addr_gen.sv
// ---------------------------------------------------------------------------
// tb_ntt_wb_addr_gen
// Self-checking bench for the NTT write-back address sequencer. A behavioural
// model tracks the transform as a single running write index 0..127 and
// derives every address arithmetically from the stride of the stage.
// ---------------------------------------------------------------------------
module tb_ntt_wb_addr_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       res_valid;
    logic       wr_en;
    logic [6:0] wr_addr_0;
    logic [6:0] wr_addr_1;
    logic [6:0] wr_addr_2;
    logic [6:0] wr_addr_3;
    logic [1:0] cur_stage;
    logic       busy;
    logic       stage_done;
    logic       done;
    logic       err;

    int compared   = 0;
    int mismatched = 0;
    int writeCount = 0;

    // Behavioural model state
    bit   mBusy;
    bit   mDonePending;
    bit   mErr;
    int   mK;
    int   mStage;
    int   mAddr [4];
    bit   eWrEn;
    bit   eStageDone;
    bit   eDone;

    // Captured outputs of the back-to-back run, indexed by write number
    int   capAddr [128][4];
    int   capStage [128];
    int   capSd [128];

    typedef struct {
        int beat;
        int stage;
        int a0;
        int a1;
        int a2;
        int a3;
        int sdone;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    ntt_wb_addr_gen dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .res_valid  (res_valid),
        .wr_en      (wr_en),
        .wr_addr_0  (wr_addr_0),
        .wr_addr_1  (wr_addr_1),
        .wr_addr_2  (wr_addr_2),
        .wr_addr_3  (wr_addr_3),
        .cur_stage  (cur_stage),
        .busy       (busy),
        .stage_done (stage_done),
        .done       (done),
        .err        (err)
    );

    function automatic int strideOf(input int p);
        case (p)
            3:       return 32;
            2:       return 16;
            1:       return 4;
            default: return 1;
        endcase
    endfunction

    // Address of result n of the k-th write of a transform: the butterfly
    // index m is split into a part below the stride and a part that skips
    // whole 4*stride blocks.
    function automatic int refAddr(input int k, input int n);
        int p;
        int m;
        int s;
        p = 3 - k / 32;
        m = k % 32;
        s = strideOf(p);
        return (m / s) * 4 * s + (m % s) + n * s;
    endfunction

    task automatic modelReset();
        mBusy        = 1'b0;
        mDonePending = 1'b0;
        mErr         = 1'b0;
        mK           = 0;
        mStage       = 3;
        eWrEn        = 1'b0;
        eStageDone   = 1'b0;
        eDone        = 1'b0;
        for (int n = 0; n < 4; n++) mAddr[n] = 0;
    endtask

    task automatic modelStep(input bit s, input bit v);
        eWrEn      = 1'b0;
        eStageDone = 1'b0;
        eDone      = 1'b0;
        if (mBusy) begin
            if (v) begin
                eWrEn = 1'b1;
                for (int n = 0; n < 4; n++) mAddr[n] = refAddr(mK, n);
                eStageDone = (mK % 32 == 31);
                mStage = (mK == 127) ? 0 : 3 - (mK + 1) / 32;
                mK++;
                if (mK == 128) begin
                    mBusy        = 1'b0;
                    mDonePending = 1'b1;
                end
            end
        end else if (mDonePending) begin
            eDone        = 1'b1;
            mDonePending = 1'b0;
            mStage       = 3;
            if (v) mErr = 1'b1;
        end else begin
            if (s) begin
                mBusy  = 1'b1;
                mK     = 0;
                mErr   = 1'b0;
                mStage = 3;
            end else if (v) begin
                mErr = 1'b1;
            end
        end
    endtask

    task automatic checkField(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    task automatic checkOutput();
        checkField("wr_en",      32'(wr_en),      32'(eWrEn));
        checkField("wr_addr_0",  32'(wr_addr_0),  32'(mAddr[0]));
        checkField("wr_addr_1",  32'(wr_addr_1),  32'(mAddr[1]));
        checkField("wr_addr_2",  32'(wr_addr_2),  32'(mAddr[2]));
        checkField("wr_addr_3",  32'(wr_addr_3),  32'(mAddr[3]));
        checkField("cur_stage",  32'(cur_stage),  32'(mStage));
        checkField("busy",       32'(busy),       32'(mBusy));
        checkField("stage_done", 32'(stage_done), 32'(eStageDone));
        checkField("done",       32'(done),       32'(eDone));
        checkField("err",        32'(err),        32'(mErr));
    endtask

    // Drive one cycle of inputs, let the edge pass, then check the registered
    // response to that cycle.
    task automatic applyStimulus(input bit s, input bit v);
        start     = s;
        res_valid = v;
        modelStep(s, v);
        @(posedge clk);
        #1;
        start     = 1'b0;
        res_valid = 1'b0;
        if (wr_en === 1'b1) writeCount++;
        checkOutput();
    endtask

    initial begin
        vecs[0] = '{beat:   0, stage: 3, a0:   0, a1:  32, a2:  64, a3:  96, sdone: 0};
        vecs[1] = '{beat:  31, stage: 2, a0:  31, a1:  63, a2:  95, a3: 127, sdone: 1};
        vecs[2] = '{beat:  48, stage: 2, a0:  64, a1:  80, a2:  96, a3: 112, sdone: 0};
        vecs[3] = '{beat:  63, stage: 1, a0:  79, a1:  95, a2: 111, a3: 127, sdone: 1};
        vecs[4] = '{beat:  69, stage: 1, a0:  17, a1:  21, a2:  25, a3:  29, sdone: 0};
        vecs[5] = '{beat:  95, stage: 0, a0: 115, a1: 119, a2: 123, a3: 127, sdone: 1};
        vecs[6] = '{beat:  96, stage: 0, a0:   0, a1:   1, a2:   2, a3:   3, sdone: 0};
        vecs[7] = '{beat: 127, stage: 0, a0: 124, a1: 125, a2: 126, a3: 127, sdone: 1};

        rst       = 1'b1;
        start     = 1'b0;
        res_valid = 1'b0;
        modelReset();
        #12;
        checkOutput();
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back transform, captured for the vector table
        $display("[TB] back-to-back transform");
        applyStimulus(1'b1, 1'b0);
        for (int b = 0; b < 128; b++) begin
            applyStimulus(1'b0, 1'b1);
            capAddr[b][0] = int'(wr_addr_0);
            capAddr[b][1] = int'(wr_addr_1);
            capAddr[b][2] = int'(wr_addr_2);
            capAddr[b][3] = int'(wr_addr_3);
            capStage[b]   = int'(cur_stage);
            capSd[b]      = int'(stage_done);
        end
        applyStimulus(1'b0, 1'b0);
        checkField("done_after_last", 32'(done), 32'd1);
        applyStimulus(1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            checkField($sformatf("vec%0d_a0", i), 32'(capAddr[vecs[i].beat][0]), 32'(vecs[i].a0));
            checkField($sformatf("vec%0d_a1", i), 32'(capAddr[vecs[i].beat][1]), 32'(vecs[i].a1));
            checkField($sformatf("vec%0d_a2", i), 32'(capAddr[vecs[i].beat][2]), 32'(vecs[i].a2));
            checkField($sformatf("vec%0d_a3", i), 32'(capAddr[vecs[i].beat][3]), 32'(vecs[i].a3));
            checkField($sformatf("vec%0d_stage", i), 32'(capStage[vecs[i].beat]), 32'(vecs[i].stage));
            checkField($sformatf("vec%0d_sdone", i), 32'(capSd[vecs[i].beat]), 32'(vecs[i].sdone));
        end

        // Stray beat while idle sets err; the next start clears it
        $display("[TB] idle beat and err clear");
        applyStimulus(1'b0, 1'b1);
        checkField("err_idle_beat", 32'(err), 32'd1);
        applyStimulus(1'b1, 1'b0);
        checkField("err_cleared", 32'(err), 32'd0);

        // start during RUN at beat 40 is ignored
        $display("[TB] start pulse mid-transform");
        for (int b = 0; b < 128; b++) begin
            applyStimulus(b == 40, 1'b1);
            if (b == 41) checkField("beat41_a0", 32'(wr_addr_0), 32'd9);
        end
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);

        // Random gaps between beats
        $display("[TB] gapped transform");
        applyStimulus(1'b1, 1'b0);
        writeCount = 0;
        for (int b = 0; b < 128; b++) begin
            int gap;
            gap = int'($urandom_range(0, 5));
            for (int g = 0; g < gap; g++) applyStimulus(1'b0, 1'b0);
            applyStimulus(1'b0, 1'b1);
        end
        applyStimulus(1'b0, 1'b0);
        checkField("gapped_writes", 32'(writeCount), 32'd128);
        applyStimulus(1'b0, 1'b0);

        // start and beat together: beat dropped, no error
        $display("[TB] start with coincident beat, then reset mid-transform");
        applyStimulus(1'b1, 1'b1);
        checkField("start_beat_err", 32'(err), 32'd0);
        for (int b = 0; b <= 74; b++) applyStimulus(1'b0, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput();
        checkField("rst_cur_stage", 32'(cur_stage), 32'd3);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkField("restart_a1", 32'(wr_addr_1), 32'd32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
